// File: rtl/msaga_tsi_mem_bridge.sv
// msaga_tsi_mem_bridge: parses host TSI read/write packets and issues
// one-at-a-time single-word requests on a simple memory port.
module msaga_tsi_mem_bridge #(
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              tsi_in_valid,
   output logic              tsi_in_ready,
   input  logic [31:0]       tsi_in_bits,
   output logic              tsi_out_valid,
   input  logic              tsi_out_ready,
   output logic [31:0]       tsi_out_bits,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_write,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [31:0]       mem_req_data,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_resp_data,
   output logic              error
);
   typedef enum logic [3:0] {
      S_CMD, S_ALO, S_AHI, S_LLO, S_LHI, S_WDATA, S_WREQ, S_RREQ, S_WAIT, S_RSEND
   } state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] addr;
   logic [31:0] cnt, wdata, rdata;
   logic wr, err, live, in_hs, last, step;
   assign in_hs = tsi_in_valid & tsi_in_ready;
   assign last = cnt == 32'd0;
   assign step = (state == S_WAIT && wr && mem_resp_valid) || (state == S_RSEND && tsi_out_ready);
   assign mem_req_addr = addr;
   assign mem_req_data = wdata;
   assign tsi_out_bits = rdata;
   assign error = err;
   always_ff @(posedge clock) begin
      if (reset) state <= S_CMD;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         S_CMD:   if (in_hs && tsi_in_bits <= 32'd1) state_nx = S_ALO;
         S_ALO:   if (in_hs) state_nx = S_AHI;
         S_AHI:   if (in_hs) state_nx = S_LLO;
         S_LLO:   if (in_hs) state_nx = S_LHI;
         S_LHI:   if (in_hs) state_nx = wr ? S_WDATA : S_RREQ;
         S_WDATA: if (in_hs) state_nx = S_WREQ;
         S_WREQ:  if (mem_req_ready) state_nx = S_WAIT;
         S_RREQ:  if (mem_req_ready) state_nx = S_WAIT;
         S_WAIT:  if (mem_resp_valid) state_nx = wr ? (last ? S_CMD : S_WDATA) : S_RSEND;
         S_RSEND: if (tsi_out_ready) state_nx = last ? S_CMD : S_RREQ;
         default: state_nx = S_CMD;
      endcase
   end
   // live keeps tsi_in_ready low while reset is held, without any input path
   always_comb begin
      tsi_in_ready = live && (state inside {S_CMD, S_ALO, S_AHI, S_LLO, S_LHI, S_WDATA});
      mem_req_valid = state == S_WREQ || state == S_RREQ;
      mem_req_write = state == S_WREQ;
      tsi_out_valid = state == S_RSEND;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         addr  <= '0;
         cnt   <= '0;
         wdata <= '0;
         rdata <= '0;
         wr    <= 1'b0;
         err   <= 1'b0;
         live  <= 1'b0;
      end else begin
         live <= 1'b1;
         if (state == S_CMD && in_hs) begin
            if (tsi_in_bits > 32'd1) err <= 1'b1;
            else wr <= tsi_in_bits[0];
         end
         if (state == S_ALO && in_hs) addr <= ADDR_W'({tsi_in_bits[31:2], 2'b00});
         if (state == S_AHI && in_hs) addr <= ADDR_W'({tsi_in_bits, 32'(addr)});
         if (state == S_LLO && in_hs) cnt <= tsi_in_bits;
         if (state == S_WDATA && in_hs) wdata <= tsi_in_bits;
         if (state == S_WAIT && mem_resp_valid && !wr) rdata <= mem_resp_data;
         if (step) begin
            cnt  <= cnt - 32'd1;
            addr <= addr + ADDR_W'(4);
         end
      end
   end
endmodule

// File: tb/tb_msaga_tsi_mem_bridge.sv
// tb_msaga_tsi_mem_bridge: directed and random packets checked against a
// transaction-level model (expected request/output queues and a reference memory).
module tb_msaga_tsi_mem_bridge;
   logic clock = 0, reset = 1;
   logic tsi_in_valid = 0, tsi_in_ready;
   logic [31:0] tsi_in_bits = 0;
   logic tsi_out_valid, tsi_out_ready = 1;
   logic [31:0] tsi_out_bits;
   logic mem_req_valid, mem_req_ready = 1, mem_req_write;
   logic [31:0] mem_req_addr, mem_req_data;
   logic mem_resp_valid = 0;
   logic [31:0] mem_resp_data = 0;
   logic error;
   always #5 clock = ~clock;
   msaga_tsi_mem_bridge #(.ADDR_W(32)) dut (
      .clock(clock), .reset(reset),
      .tsi_in_valid(tsi_in_valid), .tsi_in_ready(tsi_in_ready), .tsi_in_bits(tsi_in_bits),
      .tsi_out_valid(tsi_out_valid), .tsi_out_ready(tsi_out_ready), .tsi_out_bits(tsi_out_bits),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .error(error)
   );
   typedef struct {logic w; logic [31:0] a; logic [31:0] d;} req_t;
   req_t exp_req[$];
   logic [31:0] exp_out[$];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] sim_mem [logic [31:0]];
   int total = 0, bad = 0;
   int rdy_mode = 0, out_mode = 0, cd = 0;
   bit acc = 0, exp_err = 0;
   logic [31:0] rsp_d = 0, last_out = 0;
   req_t e;
   logic pv = 0, pw = 0, po = 0;
   logic [31:0] pa = 0, pd = 0, pb = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
   endfunction

   // memory side: accept at negedge sample, answer 1..3 cycles later
   always @(negedge clock) begin
      if (!reset && mem_req_valid && mem_req_ready) begin
         check("req_expected", 64'(exp_req.size() > 0), 64'd1);
         if (exp_req.size() > 0) begin
            e = exp_req.pop_front();
            check("req_write", mem_req_write, e.w);
            check("req_addr", mem_req_addr, e.a);
            if (e.w) check("req_data", mem_req_data, e.d);
         end
         if (mem_req_write) sim_mem[mem_req_addr] = mem_req_data;
         rsp_d = sim_mem.exists(mem_req_addr) ? sim_mem[mem_req_addr] : 32'd0;
         acc = 1;
      end
      if (!reset && tsi_out_valid && tsi_out_ready) begin
         check("out_expected", 64'(exp_out.size() > 0), 64'd1);
         if (exp_out.size() > 0) check("out_data", tsi_out_bits, exp_out.pop_front());
         last_out = tsi_out_bits;
      end
      if (!reset && pv) begin
         check("req_hold_valid", mem_req_valid, 1);
         check("req_hold_addr", mem_req_addr, pa);
         check("req_hold_data", mem_req_data, pd);
         check("req_hold_write", mem_req_write, pw);
      end
      if (!reset && po) begin
         check("out_hold_valid", tsi_out_valid, 1);
         check("out_hold_bits", tsi_out_bits, pb);
      end
      pv = !reset && mem_req_valid && !mem_req_ready;
      pa = mem_req_addr; pd = mem_req_data; pw = mem_req_write;
      po = !reset && tsi_out_valid && !tsi_out_ready;
      pb = tsi_out_bits;
   end

   always @(posedge clock) begin
      #1;
      mem_resp_valid = 0;
      mem_resp_data = $urandom;
      if (acc) begin acc = 0; cd = $urandom_range(1, 3); end
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin mem_resp_valid = 1; mem_resp_data = rsp_d; end
      end
      mem_req_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      tsi_out_ready = out_mode == 0 ? 1'b1 : out_mode == 1 ? ~tsi_out_ready :
                      out_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   task automatic send_word(input logic [31:0] w);
      int n = 0;
      tsi_in_valid = 1;
      tsi_in_bits = w;
      @(negedge clock);
      while (!tsi_in_ready && n < 500) begin n++; @(negedge clock); end
      check("in_accept_timeout", 64'(n < 500), 64'd1);
      @(posedge clock); #1;
      tsi_in_valid = 0;
   endtask

   task automatic send_hdr(input logic [31:0] cmd, input logic [31:0] a, input logic [31:0] len);
      send_word(cmd);
      send_word(a);
      send_word($urandom);
      send_word(len);
      send_word($urandom);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d[$]);
      logic [31:0] b = a & ~32'd3;
      send_hdr(1, a, d.size() - 1);
      foreach (d[i]) begin
         exp_req.push_back('{1'b1, b + 32'(4 * i), d[i]});
         ref_mem[b + 32'(4 * i)] = d[i];
         send_word(d[i]);
      end
   endtask

   task automatic do_read(input logic [31:0] a, input int n);
      logic [31:0] b = a & ~32'd3;
      for (int i = 0; i < n; i++) begin
         exp_req.push_back('{1'b0, b + 32'(4 * i), 32'd0});
         exp_out.push_back(ref_rd(b + 32'(4 * i)));
      end
      send_hdr(0, a, n - 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_req.size() > 0 || exp_out.size() > 0) && n < 3000) begin
         @(posedge clock); #1; n++;
      end
      check("idle_timeout", 64'(n < 3000), 64'd1);
      repeat (8) @(posedge clock);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"}, tsi_in_ready, 0);
      check({tag, "_out_valid"}, tsi_out_valid, 0);
      check({tag, "_out_bits"}, tsi_out_bits, 0);
      check({tag, "_req_valid"}, mem_req_valid, 0);
      check({tag, "_req_write"}, mem_req_write, 0);
      check({tag, "_req_addr"}, mem_req_addr, 0);
      check({tag, "_req_data"}, mem_req_data, 0);
      check({tag, "_error"}, error, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] d[$];
      repeat (3) @(posedge clock);
      #1;
      check_zero("rst");
      reset = 0;
      @(posedge clock); #1;
      check("post_rst_in_ready", tsi_in_ready, 1);
      check("post_rst_req_valid", mem_req_valid, 0);
      // single write then read back
      d = '{32'hDEADBEEF};
      do_write(32'h100, d);
      do_read(32'h100, 1);
      wait_idle();
      check("t1_readback", last_out, 32'hDEADBEEF);
      // burst of four with a toggling output ready
      out_mode = 1;
      d = '{32'h11, 32'h22, 32'h33, 32'h44};
      do_write(32'h2000, d);
      do_read(32'h2000, 4);
      wait_idle();
      check("t2_last_word", last_out, 32'h44);
      out_mode = 0;
      // illegal command consumes one word only
      check("t3_err_before", error, 0);
      send_word(32'd7);
      check("t3_err_set", error, 1);
      check("t3_in_ready", tsi_in_ready, 1);
      check("t3_no_req", mem_req_valid, 0);
      do_read(32'h2004, 1);
      wait_idle();
      check("t3_read_ok", last_out, 32'h22);
      check("t3_err_sticky", error, 1);
      // memory backpressure during a write
      rdy_mode = 2;
      d = '{32'hCAFEF00D};
      do_write(32'h3000, d);
      n = 0;
      while (!mem_req_valid && n < 100) begin @(posedge clock); #1; n++; end
      check("t4_req_seen", 64'(n < 100), 64'd1);
      repeat (5) begin
         @(posedge clock); #1;
         check("t4_valid", mem_req_valid, 1);
         check("t4_addr", mem_req_addr, 32'h3000);
         check("t4_data", mem_req_data, 32'hCAFEF00D);
         check("t4_write", mem_req_write, 1);
         check("t4_in_ready", tsi_in_ready, 0);
      end
      rdy_mode = 0;
      n = 0;
      do begin
         @(negedge clock);
         check("t4_in_ready_wait", tsi_in_ready, 0);
         n++;
      end while (!mem_resp_valid && n < 50);
      check("t4_resp_seen", 64'(n < 50), 64'd1);
      @(posedge clock); #1;
      check("t4_in_ready_back", tsi_in_ready, 1);
      wait_idle();
      // address wrap at the top of a 32-bit space
      d = '{32'hA5A5A5A5, 32'h5A5A5A5A};
      do_write(32'hFFFFFFFC, d);
      do_read(32'hFFFFFFFF, 2);
      wait_idle();
      check("t5_wrap_word", last_out, 32'h5A5A5A5A);
      // reset while holding read data for the host
      d = '{32'h1, 32'h2, 32'h3};
      do_write(32'h4000, d);
      out_mode = 3;
      do_read(32'h4000, 3);
      n = 0;
      while (!tsi_out_valid && n < 200) begin @(posedge clock); #1; n++; end
      check("t6_out_seen", 64'(n < 200), 64'd1);
      reset = 1;
      @(posedge clock); #1;
      check_zero("t6_rst");
      exp_req.delete();
      exp_out.delete();
      out_mode = 0;
      @(posedge clock); #1;
      reset = 0;
      repeat (6) @(posedge clock);
      #1;
      do_read(32'h4004, 1);
      wait_idle();
      check("t6_fresh_read", last_out, 32'h2);
      // random packet mix over a small window so reads hit earlier writes
      exp_err = 0;
      for (int k = 0; k < 30; k++) begin
         logic [31:0] a, v;
         int len;
         rdy_mode = $urandom_range(0, 1);
         out_mode = $urandom_range(0, 2);
         a = 32'h8000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
         len = $urandom_range(1, 4);
         case ($urandom_range(0, 5))
            0: begin
               v = $urandom;
               if (v <= 1) v = 32'd2;
               send_word(v);
               exp_err = 1;
            end
            1, 2, 3: begin
               d.delete();
               for (int i = 0; i < len; i++) d.push_back($urandom);
               do_write(a, d);
            end
            default: do_read(a, len);
         endcase
      end
      wait_idle();
      check("rand_error", error, exp_err);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
